ula_arbiter: RTL and testbench

ULA_ARBITER -- requirements
Module: ula_arbiter

---
 rtl/ula_arbiter_if.sv | 28 ++
 rtl/ula_arbiter.sv | 148 ++++++++++++++
 tb/tb_ula_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_arbiter_if.sv
// Bundle of the two requester channels, the two result channels and the shared-ULA drive.
// Index [n] of each packed array belongs to requester n.
interface ula_arbiter_if;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][3:0] req_sel;
  logic [1:0][1:0] req_a;
  logic [1:0][1:0] req_b;
  logic [1:0]      res_valid;
  logic [1:0]      res_ready;
  logic [1:0][1:0] res_data;
  logic [1:0]      res_err;
  logic [3:0]      ula_sel;
  logic [1:0]      ula_a;
  logic [1:0]      ula_b;
  logic [1:0]      ula_saida;
  logic            grant;

  modport master (
    output req_valid, req_sel, req_a, req_b, res_ready, ula_saida,
    input  req_ready, res_valid, res_data, res_err, ula_sel, ula_a, ula_b, grant
  );

  modport slave (
    input  req_valid, req_sel, req_a, req_b, res_ready, ula_saida,
    output req_ready, res_valid, res_data, res_err, ula_sel, ula_a, ula_b, grant
  );
endinterface

// File: rtl/ula_arbiter.sv
// Two-requester arbiter sharing one external ULA; one operation in flight (IDLE/EXEC/RESP).
// Build option: define ULA_ARB_FIXED_PRIO_EN to make requester 0 win every tie (no round-robin).

module ula_arb_res_chan (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic       i_clear,
  input  logic [1:0] i_data,
  input  logic       i_err,
  output logic       o_valid,
  output logic [1:0] o_data,
  output logic       o_err
);
  logic       r_valid;
  logic [1:0] r_data;
  logic       r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= 2'b00;
      r_err   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_err   <= i_err;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_err   = r_err;
endmodule

module ula_arbiter (
  input  logic          i_clk,
  input  logic          i_rst,
  ula_arbiter_if.slave  bus
);
  localparam logic [3:0] SEL_DIV = 4'b0011;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_grant;
  logic [3:0] r_ula_sel;
  logic [1:0] r_ula_a;
  logic [1:0] r_ula_b;
  logic       w_win;
  logic [1:0] w_ready;
  logic       w_accept;
  logic       w_release;
  logic       w_div0;
  logic [1:0] w_res_data;
  logic [1:0] w_res_valid;
  logic [1:0][1:0] w_res_dat;
  logic [1:0] w_res_err;

`ifdef ULA_ARB_FIXED_PRIO_EN
  always_comb begin
    w_win = 1'b0;
    if (bus.req_valid == 2'b10) w_win = 1'b1;
  end
`else
  logic r_ptr;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    w_win = 1'b0;
    if (bus.req_valid == 2'b10)      w_win = 1'b1;
    else if (bus.req_valid == 2'b11) w_win = r_ptr;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)          r_ptr <= 1'b0;
    else if (w_release) r_ptr <= ~r_grant;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 2'b00;
    case (r_state)
      IDLE: begin
        if (!i_rst && bus.req_valid[w_win]) begin
          w_ready[w_win] = 1'b1;
          w_next         = EXEC;
        end
      end
      EXEC: w_next = RESP;
      RESP: if (bus.res_ready[r_grant]) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_accept  = (r_state == IDLE) && bus.req_valid[w_win];
  assign w_release = (r_state == RESP) && bus.res_ready[r_grant];

  // ULA drive only moves on an accept, so it is quiet between operations.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant   <= 1'b0;
      r_ula_sel <= 4'h0;
      r_ula_a   <= 2'b00;
      r_ula_b   <= 2'b00;
    end else if (w_accept) begin
      r_grant   <= w_win;
      r_ula_sel <= bus.req_sel[w_win];
      r_ula_a   <= bus.req_a[w_win];
      r_ula_b   <= bus.req_b[w_win];
    end
  end

  assign w_div0     = (r_ula_sel == SEL_DIV) && (r_ula_b == 2'b00);
  assign w_res_data = w_div0 ? 2'b00 : bus.ula_saida;

  for (genvar g = 0; g < 2; g++) begin : g_res
    ula_arb_res_chan u_chan (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  ((r_state == EXEC) && (r_grant == 1'(g))),
      .i_clear (w_release && (r_grant == 1'(g))),
      .i_data  (w_res_data),
      .i_err   (w_div0),
      .o_valid (w_res_valid[g]),
      .o_data  (w_res_dat[g]),
      .o_err   (w_res_err[g])
    );
  end

  assign bus.req_ready = w_ready;
  assign bus.res_valid = w_res_valid;
  assign bus.res_data  = w_res_dat;
  assign bus.res_err   = w_res_err;
  assign bus.ula_sel   = r_ula_sel;
  assign bus.ula_a     = r_ula_a;
  assign bus.ula_b     = r_ula_b;
  assign bus.grant     = r_grant;
endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_ula_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ula_arbiter_if bus();

  ula_arbiter dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  // Behavioural ULA; division by zero yields 11 so the arbiter's override is observable.
  function automatic logic [1:0] ula_fn(input logic [3:0] s, input logic [1:0] a, input logic [1:0] b);
    case (s)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a * b;
      4'h3: return (b == 2'b00) ? 2'b11 : a / b;
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return a ^ b;
      4'h7: return ~a;
      4'hF: return {1'b0, a == b};
      default: return a;
    endcase
  endfunction

  always_comb bus.ula_saida = ula_fn(bus.ula_sel, bus.ula_a, bus.ula_b);

  // Expected {err, data} of a completed operation.
  function automatic logic [2:0] expect_res(input logic [3:0] s, input logic [1:0] a, input logic [1:0] b);
    if (s == 4'h3 && b == 2'b00) return 3'b100;
    return {1'b0, ula_fn(s, a, b)};
  endfunction

  function automatic int pick(input logic [1:0] v, input int ptr);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
`ifdef ULA_ARB_FIXED_PRIO_EN
    return 0;
`else
    return ptr;
`endif
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    bus.req_valid = 2'b00;
    bus.req_sel   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 2'b11;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    bus.req_valid = 2'b11;
    #1;
    n_chk++;
    if (bus.req_ready !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 00", bus.req_ready);
    end
    n_chk++;
    if ({bus.res_valid, bus.res_data, bus.res_err, bus.ula_sel, bus.ula_a, bus.ula_b, bus.grant} !== 17'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0",
        {bus.res_valid, bus.res_data, bus.res_err, bus.ula_sel, bus.ula_a, bus.ula_b, bus.grant});
    end
    bus.req_valid = 2'b00;
    rst = 1'b0;
    tick();
  endtask

  // Drives one operation from requester r with both result readys high and checks every phase.
  task automatic run_op(input string nm, input int r, input logic [1:0] vld, input int exp_g,
                        input logic [3:0] s, input logic [1:0] a, input logic [1:0] b);
    logic [2:0] e;
    bus.req_valid = vld;
    bus.req_sel[r] = s; bus.req_a[r] = a; bus.req_b[r] = b;
    e = expect_res(s, a, b);
    #1;
    n_chk++;
    if (bus.req_ready !== (2'b01 << exp_g)) begin
      n_fail++; $display("FAIL %s_accept_ready: got %b expected %b", nm, bus.req_ready, 2'b01 << exp_g);
    end
    tick();
    n_chk++;
    if ({bus.grant, bus.res_valid, bus.req_ready} !== {1'(exp_g), 4'b0000}) begin
      n_fail++; $display("FAIL %s_exec: got grant/rv/rdy %b expected %0d/00/00", nm,
        {bus.grant, bus.res_valid, bus.req_ready}, exp_g);
    end
    tick();
    n_chk++;
    if (bus.res_valid !== (2'b01 << exp_g) || {bus.res_err[exp_g], bus.res_data[exp_g]} !== e) begin
      n_fail++; $display("FAIL %s_result: got valid %b err/data %b expected valid %b err/data %b", nm,
        bus.res_valid, {bus.res_err[exp_g], bus.res_data[exp_g]}, 2'b01 << exp_g, e);
    end
    tick();
    n_chk++;
    if (bus.res_valid !== 2'b00) begin
      n_fail++; $display("FAIL %s_release: got %b expected 00", nm, bus.res_valid);
    end
  endtask

  task automatic test_single;
    run_op("single_add", 0, 2'b01, 0, 4'h0, 2'b01, 2'b01);
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_round_robin;
    int exp_g;
    test_reset();
    bus.req_sel[1] = 4'h2; bus.req_a[1] = 2'b01; bus.req_b[1] = 2'b10;
    for (int t = 0; t < 4; t++) begin
`ifdef ULA_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = t % 2;
`endif
      if (exp_g == 0) run_op("rr_sub", 0, 2'b11, 0, 4'h1, 2'b11, 2'b01);
      else            run_op("rr_mul", 1, 2'b11, 1, 4'h2, 2'b01, 2'b10);
    end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_div;
    run_op("div_zero", 1, 2'b10, 1, 4'h3, 2'b10, 2'b00);
    bus.req_valid = 2'b00;
    tick();
    run_op("div_one", 1, 2'b10, 1, 4'h3, 2'b10, 2'b01);
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_backpressure;
    test_reset();
    bus.res_ready = 2'b00;
    bus.req_valid = 2'b01;
    bus.req_sel[0] = 4'h6; bus.req_a[0] = 2'b10; bus.req_b[0] = 2'b11;
    tick(); tick();
    bus.req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++;
      if ({bus.res_valid, bus.res_data[0], bus.res_err[0], bus.req_ready} !== {2'b01, 2'b01, 1'b0, 2'b00}) begin
        n_fail++; $display("FAIL bp_hold_%0d: got rv/data/err/rdy %b expected 01/01/0/00", i,
          {bus.res_valid, bus.res_data[0], bus.res_err[0], bus.req_ready});
      end
      tick();
    end
    bus.res_ready = 2'b11;
    tick();
    n_chk++;
`ifdef ULA_ARB_FIXED_PRIO_EN
    if (bus.res_valid !== 2'b00 || bus.req_ready !== 2'b01) begin
`else
    if (bus.res_valid !== 2'b00 || bus.req_ready !== 2'b10) begin
`endif
      n_fail++; $display("FAIL bp_release: got rv %b rdy %b", bus.res_valid, bus.req_ready);
    end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_in_exec;
    bus.req_valid = 2'b10;
    bus.req_sel[1] = 4'h5; bus.req_a[1] = 2'b01; bus.req_b[1] = 2'b10;
    tick();
    bus.req_valid = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({bus.res_valid, bus.res_data, bus.res_err, bus.ula_sel, bus.ula_a, bus.ula_b, bus.grant} !== 17'h0) begin
      n_fail++; $display("FAIL rst_exec_outputs: got %h expected 0",
        {bus.res_valid, bus.res_data, bus.res_err, bus.ula_sel, bus.ula_a, bus.ula_b, bus.grant});
    end
    tick();
    n_chk++;
    if (bus.res_valid !== 2'b00) begin
      n_fail++; $display("FAIL rst_exec_discard: got %b expected 00", bus.res_valid);
    end
    bus.req_sel[1] = 4'h0;
    run_op("rst_exec_tie", 0, 2'b11, 0, 4'h4, 2'b11, 2'b10);
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_random;
    int ptr = 0, g = 0, w = 0, phase = 0;
    bit busy = 0;
    logic [2:0] e = '0;
    logic [7:0] last = '0;
    logic [1:0] exp_rdy;
    test_reset();
    for (int c = 0; c < 400; c++) begin
      n_chk++;
      if (bus.res_valid !== ((busy && phase == 1) ? (2'b01 << g) : 2'b00) ||
          {bus.ula_sel, bus.ula_a, bus.ula_b} !== last ||
          (busy && phase == 1 && {bus.res_err[g], bus.res_data[g], bus.grant} !== {e, 1'(g)})) begin
        n_fail++; $display("FAIL rand_out_c%0d: got rv %b ula %h grant %b expected busy %0b g %0d ula %h res %b",
          c, bus.res_valid, {bus.ula_sel, bus.ula_a, bus.ula_b}, bus.grant, busy, g, last, e);
      end
      bus.req_valid = 2'($urandom_range(3));
      bus.res_ready = 2'($urandom_range(3));
      for (int r = 0; r < 2; r++) begin
        bus.req_sel[r] = 4'($urandom_range(15));
        bus.req_a[r]   = 2'($urandom_range(3));
        bus.req_b[r]   = 2'($urandom_range(3));
      end
      #1;
      w = pick(bus.req_valid, ptr);
      exp_rdy = (!busy && bus.req_valid != 2'b00) ? (2'b01 << w) : 2'b00;
      n_chk++;
      if (bus.req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rand_ready_c%0d: got %b expected %b", c, bus.req_ready, exp_rdy);
      end
      tick();
      if (!busy && bus.req_valid != 2'b00) begin
        busy = 1; phase = 0; g = w;
        last = {bus.req_sel[w], bus.req_a[w], bus.req_b[w]};
        e = expect_res(bus.req_sel[w], bus.req_a[w], bus.req_b[w]);
      end else if (busy && phase == 0) begin
        phase = 1;
      end else if (busy && bus.res_ready[g]) begin
        busy = 0; ptr = 1 - g;
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_div();
    test_backpressure();
    test_reset_in_exec();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
